camera_input_framer: RTL and testbench

- Successor to the single-pair camera input stage: registers raw camera LVAL/FVAL/DVAL plus NUM_CH pixel lanes, normalises sync polarity and gates DE to whole frames.
- Adds per-pixel X/Y coordinates, SOF/EOL/EOF pulses, field and frame counters, and measured line/frame geometry with sticky mismatch errors.
- Sits between the camera pads/deserialiser and the eye-tracking pixel pipeline.

---
 rtl/camera_input_framer.sv | 223 ++++++++++++++++++++++
 tb/tb_camera_input_framer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_input_framer.sv
// Camera input framer: two-stage registered sync normalisation, frame gating,
// per-pixel X/Y coordinates, SOF/EOL/EOF pulses and measured line/frame geometry.
module camera_input_framer #(
  parameter int NUM_CH        = 2,
  parameter int PIXEL_WIDTH   = 8,
  parameter int H_CNT_WIDTH   = 12,
  parameter int V_CNT_WIDTH   = 11,
  parameter int FRM_CNT_WIDTH = 8
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          iLVAL_POL,
  input  logic                          iFVAL_POL,
  input  logic                          iDVAL_POL,
  input  logic                          iLVAL,
  input  logic                          iFVAL,
  input  logic                          iDVAL,
  input  logic [NUM_CH*PIXEL_WIDTH-1:0] iDATA,
  input  logic [H_CNT_WIDTH-1:0]        iEXP_PIX,
  input  logic [V_CNT_WIDTH-1:0]        iEXP_LINE,
  input  logic                          iCLR_ERR,
  output logic                          oVSYNC,
  output logic                          oHSYNC,
  output logic                          oDE,
  output logic                          oFIELD,
  output logic [NUM_CH*PIXEL_WIDTH-1:0] oDATA,
  output logic [H_CNT_WIDTH-1:0]        oX,
  output logic [V_CNT_WIDTH-1:0]        oY,
  output logic                          oSOF,
  output logic                          oEOL,
  output logic                          oEOF,
  output logic [H_CNT_WIDTH-1:0]        oPIX_CNT,
  output logic [V_CNT_WIDTH-1:0]        oLINE_CNT,
  output logic [FRM_CNT_WIDTH-1:0]      oFRAME_CNT,
  output logic                          oERR_H,
  output logic                          oERR_V
);

  localparam int DW = NUM_CH * PIXEL_WIDTH;
  localparam logic [H_CNT_WIDTH-1:0] X_MAX = '1;
  localparam logic [V_CNT_WIDTH-1:0] Y_MAX = '1;

  typedef enum logic [1:0] {SYNC_WAIT = 2'd0, IDLE = 2'd1, FRAME = 2'd2} state_t;

  // stage 1: polarity-normalised input samples
  logic          vld1_q, f1_q, l1_q, d1_q, clr1_q, l1p_q;
  logic          vld1_d, f1_d, l1_d, d1_d, clr1_d, l1p_d;
  logic [DW-1:0] data1_q, data1_d;

  // frame tracking state
  state_t                   state_q, state_d;
  logic [H_CNT_WIDTH-1:0]   x_q, x_d;
  logic [V_CNT_WIDTH-1:0]   y_q, y_d;

  // stage 2: registered outputs
  logic                     vsync_q, hsync_q, de_q, field_q, sof_q, eol_q, eof_q, err_h_q, err_v_q;
  logic                     vsync_d, hsync_d, de_d, field_d, sof_d, eol_d, eof_d, err_h_d, err_v_d;
  logic [DW-1:0]            data_q, data_d;
  logic [H_CNT_WIDTH-1:0]   ox_q, ox_d, pix_cnt_q, pix_cnt_d;
  logic [V_CNT_WIDTH-1:0]   oy_q, oy_d, line_cnt_q, line_cnt_d;
  logic [FRM_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

  logic                   in_frame, frame_start, frame_end, l_rise, de, line_end;
  logic [H_CNT_WIDTH-1:0] x_cur;
  logic [V_CNT_WIDTH-1:0] y_cur, y_line;

  // next-state, counters and output values from the stage-1 sample
  always_comb begin
    vld1_d  = 1'b1;
    f1_d    = iFVAL ^ iFVAL_POL;
    l1_d    = iLVAL ^ iLVAL_POL;
    d1_d    = iDVAL ^ iDVAL_POL;
    clr1_d  = iCLR_ERR;
    data1_d = iDATA;
    l1p_d   = l1_q;

    // a sample belongs to a frame once the FSM has seen a clean f-low period
    in_frame    = f1_q && (state_q != SYNC_WAIT);
    frame_start = (state_q == IDLE) && f1_q;
    frame_end   = (state_q == FRAME) && !f1_q;
    l_rise      = l1_q && !l1p_q;
    de          = in_frame && l1_q && d1_q;
    // a line with at least one DE closes on l falling or on the frame closing under it
    line_end    = (state_q == FRAME) && (x_q != '0) && (!l1_q || !f1_q);

    state_d = state_q;
    case (state_q)
      SYNC_WAIT: if (vld1_q && !f1_q) state_d = IDLE;
      IDLE:      if (f1_q)            state_d = FRAME;
      FRAME:     if (!f1_q)           state_d = IDLE;
      default:                        state_d = SYNC_WAIT;
    endcase

    x_cur = (l_rise || frame_start) ? '0 : x_q;
    y_cur = frame_start ? '0 : y_q;
    x_d   = x_cur;
    y_d   = y_cur;

    vsync_d     = f1_q && (state_q != SYNC_WAIT);
    hsync_d     = l1_q && in_frame;
    de_d        = de;
    data_d      = data1_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    sof_d       = 1'b0;
    eol_d       = line_end;
    eof_d       = frame_end;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    frame_cnt_d = frame_cnt_q;
    field_d     = field_q;
    // clear first so that a set event in the same cycle wins
    err_h_d     = err_h_q && !clr1_q;
    err_v_d     = err_v_q && !clr1_q;

    if (de) begin
      ox_d  = x_cur;
      oy_d  = y_cur;
      sof_d = (x_cur == '0) && (y_cur == '0);
      if (x_cur == X_MAX) err_h_d = 1'b1;
      else                x_d     = x_cur + 1'b1;
    end

    y_line = y_q;
    if (line_end) begin
      pix_cnt_d = x_q;
      if ((iEXP_PIX != '0) && (x_q != iEXP_PIX)) err_h_d = 1'b1;
      x_d = '0;
      if (y_q == Y_MAX) err_v_d = 1'b1;
      else              y_line  = y_q + 1'b1;
      y_d = y_line;
    end

    // y_line already includes a line closing in the same cycle
    if (frame_end) begin
      line_cnt_d = y_line;
      if ((iEXP_LINE != '0) && (y_line != iEXP_LINE)) err_v_d = 1'b1;
      field_d     = !field_q;
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  // stage-1 input registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld1_q  <= 1'b0;
      f1_q    <= 1'b0;
      l1_q    <= 1'b0;
      d1_q    <= 1'b0;
      clr1_q  <= 1'b0;
      l1p_q   <= 1'b0;
      data1_q <= '0;
    end else begin
      vld1_q  <= vld1_d;
      f1_q    <= f1_d;
      l1_q    <= l1_d;
      d1_q    <= d1_d;
      clr1_q  <= clr1_d;
      l1p_q   <= l1p_d;
      data1_q <= data1_d;
    end
  end

  // FSM, counters and stage-2 output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= SYNC_WAIT;
      x_q         <= '0;
      y_q         <= '0;
      vsync_q     <= 1'b0;
      hsync_q     <= 1'b0;
      de_q        <= 1'b0;
      field_q     <= 1'b0;
      data_q      <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
      err_h_q     <= 1'b0;
      err_v_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vsync_q     <= vsync_d;
      hsync_q     <= hsync_d;
      de_q        <= de_d;
      field_q     <= field_d;
      data_q      <= data_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_h_q     <= err_h_d;
      err_v_q     <= err_v_d;
    end
  end

  assign oVSYNC     = vsync_q;
  assign oHSYNC     = hsync_q;
  assign oDE        = de_q;
  assign oFIELD     = field_q;
  assign oDATA      = data_q;
  assign oX         = ox_q;
  assign oY         = oy_q;
  assign oSOF       = sof_q;
  assign oEOL       = eol_q;
  assign oEOF       = eof_q;
  assign oPIX_CNT   = pix_cnt_q;
  assign oLINE_CNT  = line_cnt_q;
  assign oFRAME_CNT = frame_cnt_q;
  assign oERR_H     = err_h_q;
  assign oERR_V     = err_v_q;

endmodule

// File: tb/tb_camera_input_framer.sv
// Self-checking bench for camera_input_framer: frames are described at the
// line/pixel level and the expected pixel, line-end and frame-end events are
// queued from that description, then matched against the DUT outputs.
module tb_camera_input_framer;

  localparam int NCH = 4, PW = 10, HW = 12, VW = 11, FW = 8;
  localparam int DW = NCH * PW;

  logic CLK = 1'b0, RST_N = 1'b0;
  logic pol_l = 1'b0, pol_f = 1'b0, pol_d = 1'b0;
  logic iLVAL = 1'b0, iFVAL = 1'b0, iDVAL = 1'b0, iCLR_ERR = 1'b0;
  logic [DW-1:0] iDATA = '0;
  logic [HW-1:0] exp_pix = '0;
  logic [VW-1:0] exp_line = '0;
  logic oVSYNC, oHSYNC, oDE, oFIELD, oSOF, oEOL, oEOF, oERR_H, oERR_V;
  logic [DW-1:0] oDATA;
  logic [HW-1:0] oX, oPIX_CNT;
  logic [VW-1:0] oY, oLINE_CNT;
  logic [FW-1:0] oFRAME_CNT;

  camera_input_framer #(.NUM_CH(NCH), .PIXEL_WIDTH(PW), .H_CNT_WIDTH(HW),
                        .V_CNT_WIDTH(VW), .FRM_CNT_WIDTH(FW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .iLVAL_POL(pol_l), .iFVAL_POL(pol_f), .iDVAL_POL(pol_d),
    .iLVAL(iLVAL), .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA),
    .iEXP_PIX(exp_pix), .iEXP_LINE(exp_line), .iCLR_ERR(iCLR_ERR),
    .oVSYNC(oVSYNC), .oHSYNC(oHSYNC), .oDE(oDE), .oFIELD(oFIELD), .oDATA(oDATA),
    .oX(oX), .oY(oY), .oSOF(oSOF), .oEOL(oEOL), .oEOF(oEOF),
    .oPIX_CNT(oPIX_CNT), .oLINE_CNT(oLINE_CNT), .oFRAME_CNT(oFRAME_CNT),
    .oERR_H(oERR_H), .oERR_V(oERR_V)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] data; int x; int y; bit sof; int cyc; } pix_t;
  typedef struct { int cnt; bit errh; int cyc; } eol_t;
  typedef struct { int lines; logic [FW-1:0] fcnt; bit field; bit errh; bit errv; int cyc; } eof_t;

  pix_t pq[$];
  eol_t lq[$];
  eof_t fq[$];
  pix_t pe;
  eol_t le;
  eof_t fe;

  int n_chk = 0, n_err = 0;
  bit mon_on = 1'b1;
  bit m_errh = 1'b0, m_errv = 1'b0, m_field = 1'b0;
  logic [FW-1:0] m_fcnt = '0;
  int frames_done = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(1));
  endfunction

  // drive one cycle of logical sync values (polarity applied here)
  task automatic drv(input bit f, input bit l, input bit d, input bit c,
                     output logic [DW-1:0] px, output int dc);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    px = r[DW-1:0];
    iFVAL = f ^ pol_f; iLVAL = l ^ pol_l; iDVAL = d ^ pol_d;
    iDATA = px; iCLR_ERR = c; dc = cyc;
    @(posedge CLK); #1;
  endtask

  task automatic set_pol(input bit p);
    pol_f = p; pol_l = p; pol_d = p;
    iFVAL = p; iLVAL = p; iDVAL = p;
  endtask

  // one frame: nl DE lines of np pixels (line short_idx one pixel short),
  // optional empty LVAL-only line after line empty_after, optional f/l drop together
  task automatic send_frame(input int nl, input int np, input int short_idx, input int empty_after,
                            input bit together, input bit vis, input bit clr_short);
    logic [DW-1:0] px; int dc; int n; bit first, last, c, mism;
    first = 1'b1;
    repeat (2) drv(1, 0, rb(), 0, px, dc);
    for (int li = 0; li < nl; li++) begin
      n = (li == short_idx) ? np - 1 : np;
      for (int p = 0; p < n; p++) begin
        if ($urandom_range(3) == 0) drv(1, 1, 0, 0, px, dc);
        drv(1, 1, 1, 0, px, dc);
        if (vis) pq.push_back('{px, p, li, first, dc});
        first = 1'b0;
      end
      last = (li == nl - 1) && together;
      c = clr_short && (li == short_idx);
      drv(!last, 0, rb(), c, px, dc);
      if (vis) begin
        mism = (exp_pix != 0) && (n != int'(exp_pix));
        m_errh = (m_errh && !c) || mism;
        lq.push_back('{n, m_errh, dc});
      end
      if (!last) begin
        drv(1, 0, rb(), 0, px, dc);
        if (li == empty_after) begin
          repeat (3) drv(1, 1, 0, 0, px, dc);
          repeat (2) drv(1, 0, rb(), 0, px, dc);
        end
      end
    end
    if (!together) drv(0, 0, rb(), 0, px, dc);
    if (vis) begin
      m_errv = m_errv || ((exp_line != 0) && (nl != int'(exp_line)));
      m_field = !m_field;
      m_fcnt = m_fcnt + 1'b1;
      frames_done++;
      fq.push_back('{nl, m_fcnt, m_field, m_errh, m_errv, dc});
    end
    repeat (3) drv(0, 0, rb(), 0, px, dc);
  endtask

  task automatic clear_err();
    logic [DW-1:0] px; int dc;
    drv(0, 0, 0, 1, px, dc);
    m_errh = 1'b0; m_errv = 1'b0;
    repeat (2) drv(0, 0, 0, 0, px, dc);
    chk("errh_clr", 64'(oERR_H), 64'(m_errh));
    chk("errv_clr", 64'(oERR_V), 64'(m_errv));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vsync"}, 64'(oVSYNC), 0);   chk({tag, "_hsync"}, 64'(oHSYNC), 0);
    chk({tag, "_de"}, 64'(oDE), 0);         chk({tag, "_field"}, 64'(oFIELD), 0);
    chk({tag, "_data"}, 64'(oDATA), 0);     chk({tag, "_x"}, 64'(oX), 0);
    chk({tag, "_y"}, 64'(oY), 0);           chk({tag, "_sof"}, 64'(oSOF), 0);
    chk({tag, "_eol"}, 64'(oEOL), 0);       chk({tag, "_eof"}, 64'(oEOF), 0);
    chk({tag, "_pixcnt"}, 64'(oPIX_CNT), 0); chk({tag, "_linecnt"}, 64'(oLINE_CNT), 0);
    chk({tag, "_frmcnt"}, 64'(oFRAME_CNT), 0);
    chk({tag, "_errh"}, 64'(oERR_H), 0);    chk({tag, "_errv"}, 64'(oERR_V), 0);
  endtask

  // scoreboard: match every DE, EOL and EOF against the queued expectations
  always @(negedge CLK) begin
    if (mon_on) begin
      if (oDE) begin
        if (pq.size() == 0) chk("de_extra", 64'(oDE), 0);
        else begin
          pe = pq.pop_front();
          chk("data", 64'(oDATA), 64'(pe.data));
          chk("x", 64'(oX), 64'(pe.x));
          chk("y", 64'(oY), 64'(pe.y));
          chk("sof", 64'(oSOF), 64'(pe.sof));
          chk("de_lat", 64'(cyc), 64'(pe.cyc + 2));
        end
      end else if (oSOF) chk("sof_noDE", 64'(oSOF), 0);
      if (oEOL) begin
        if (lq.size() == 0) chk("eol_extra", 64'(oEOL), 0);
        else begin
          le = lq.pop_front();
          chk("pix_cnt", 64'(oPIX_CNT), 64'(le.cnt));
          chk("eol_errh", 64'(oERR_H), 64'(le.errh));
          chk("eol_lat", 64'(cyc), 64'(le.cyc + 2));
        end
      end
      if (oEOF) begin
        if (fq.size() == 0) chk("eof_extra", 64'(oEOF), 0);
        else begin
          fe = fq.pop_front();
          chk("line_cnt", 64'(oLINE_CNT), 64'(fe.lines));
          chk("frame_cnt", 64'(oFRAME_CNT), 64'(fe.fcnt));
          chk("field", 64'(oFIELD), 64'(fe.field));
          chk("eof_errh", 64'(oERR_H), 64'(fe.errh));
          chk("eof_errv", 64'(oERR_V), 64'(fe.errv));
          chk("eof_lat", 64'(cyc), 64'(fe.cyc + 2));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] px; int dc; int nl, np;
    // reset with a frame already in progress
    iFVAL = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk_all_zero("rst");
    RST_N = 1'b1;
    send_frame(3, 4, -1, -1, 0, 0, 0);
    // first full frame
    send_frame(3, 4, -1, -1, 0, 1, 0);
    // inverted polarity with matching expected geometry
    set_pol(1'b1);
    exp_pix = 12'd16; exp_line = 11'd6;
    send_frame(6, 16, -1, -1, 0, 1, 0);
    chk("no_errh", 64'(oERR_H), 0);
    chk("no_errv", 64'(oERR_V), 0);
    set_pol(1'b0);
    // short line sets sticky error; clear coinciding with a new mismatch keeps it
    exp_pix = 12'd8; exp_line = 11'd0;
    send_frame(3, 8, 1, -1, 0, 1, 0);
    chk("errh_sticky", 64'(oERR_H), 64'(m_errh));
    send_frame(3, 8, 0, -1, 0, 1, 1);
    chk("errh_clr_set", 64'(oERR_H), 64'(m_errh));
    clear_err();
    // f and l fall together after 5 lines
    exp_pix = 12'd0; exp_line = 11'd5;
    send_frame(5, 6, -1, -1, 1, 1, 0);
    // LVAL-only line between lines 1 and 2
    exp_line = 11'd4;
    send_frame(4, 5, -1, 1, 0, 1, 0);
    chk("empty_errv", 64'(oERR_V), 64'(m_errv));
    // randomised frames
    for (int i = 0; i < 8; i++) begin
      nl = $urandom_range(1, 5);
      np = $urandom_range(2, 10);
      exp_pix  = rb() ? HW'(np) : '0;
      exp_line = rb() ? VW'(nl) : '0;
      set_pol(rb());
      send_frame(nl, np, rb() ? int'($urandom_range(nl - 1)) : -1,
                 rb() ? int'($urandom_range(nl - 1)) : -1, rb(), 1, 0);
    end
    set_pol(1'b0);
    clear_err();
    // frame counter wrap
    exp_pix = '0; exp_line = '0;
    while (frames_done < 256) send_frame(1, 1, -1, -1, rb(), 1, 0);
    chk("frm_wrap", 64'(oFRAME_CNT), 0);
    chk("pix_left", 64'(pq.size()), 0);
    chk("eol_left", 64'(lq.size()), 0);
    chk("eof_left", 64'(fq.size()), 0);
    // asynchronous reset in the middle of a line
    mon_on = 1'b0;
    repeat (2) drv(1, 0, 0, 0, px, dc);
    repeat (3) drv(1, 1, 1, 0, px, dc);
    #1;
    chk("de_before_rst", 64'(oDE), 1);
    #1;
    RST_N = 1'b0;
    #1;
    chk_all_zero("async_rst");
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
